// File: rtl/mvu_replay_pkg.sv
// Shared definitions for the replaying matrix-vector / vector-vector unit.
//   ceil8()  : rounds a bit count up to a whole number of bytes (AXI-Stream tdata width)
//   cnt_w()  : width of a counter addressing n entries, never narrower than 1 bit
//   state_e  : FILL streams activations in, REPLAY reuses the buffered vector
package mvu_replay_pkg;

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    REPLAY = 1'b1
  } state_e;

  function automatic int ceil8(input int bits);
    return ((bits + 7) / 8) * 8;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvu_replay_dotp.sv
// PE x SIMD multiply, per-PE adder tree and accumulator. Pure datapath.
//   clk, rst : clock and synchronous active-high reset (clears the accumulators)
//   en       : a compute beat fires this cycle; the accumulators take acc_sum
//   clr      : first beat of a row (sf==0); the old accumulator value is ignored
//   act      : activations, SIMD elements (shared) or [PE][SIMD] elements (per channel)
//   wgt      : signed weights packed [PE][SIMD]
//   acc_sum  : combinational accumulator value after this beat, packed [PE]
module mvu_replay_dotp
  import mvu_replay_pkg::*;
#(
  parameter int IS_MVU             = 1,
  parameter int PE                 = 10,
  parameter int SIMD               = 20,
  parameter int AI                 = 20,
  parameter int ACTIVATION_WIDTH   = 4,
  parameter int WEIGHT_WIDTH       = 4,
  parameter int ACCU_WIDTH         = 15,
  parameter int SIGNED_ACTIVATIONS = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic                               clr,
  input  logic [AI*ACTIVATION_WIDTH-1:0]     act,
  input  logic [PE*SIMD*WEIGHT_WIDTH-1:0]    wgt,
  output logic [PE*ACCU_WIDTH-1:0]           acc_sum
);

  localparam int AW = ACTIVATION_WIDTH;
  localparam int WW = WEIGHT_WIDTH;
  // one extra activation bit so unsigned values survive as signed operands
  localparam int PW = AW + 1 + WW;

  typedef logic signed [AW:0]           act_ext_t;
  typedef logic signed [WW-1:0]         wgt_t;
  typedef logic signed [PW-1:0]         prod_t;
  typedef logic signed [ACCU_WIDTH-1:0] acc_t;

  logic [PE*ACCU_WIDTH-1:0] acc_q;

  always_comb begin
    acc_t     sum;
    act_ext_t ax;
    wgt_t     wx;
    prod_t    pr;
    logic [AW-1:0] a_raw;
    sum     = '0;
    ax      = '0;
    wx      = '0;
    pr      = '0;
    a_raw   = '0;
    acc_sum = '0;
    for (int p = 0; p < PE; p++) begin
      sum = clr ? '0 : acc_t'(acc_q[p*ACCU_WIDTH +: ACCU_WIDTH]);
      for (int s = 0; s < SIMD; s++) begin
        if (IS_MVU != 0) a_raw = act[s*AW +: AW];
        else             a_raw = act[(p*SIMD + s)*AW +: AW];
        // sign bit copied only for two's complement activations
        ax  = {(SIGNED_ACTIVATIONS != 0) & a_raw[AW-1], a_raw};
        wx  = wgt[(p*SIMD + s)*WW +: WW];
        pr  = prod_t'(ax) * prod_t'(wx);
        sum = sum + acc_t'(pr);
      end
      acc_sum[p*ACCU_WIDTH +: ACCU_WIDTH] = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)     acc_q <= '0;
    else if (en) acc_q <= acc_sum;
  end

endmodule

// File: rtl/mvu_replay_axi.sv
// AXI-Stream matrix-vector (IS_MVU=1) / vector-vector (IS_MVU=0) unit.
// In MVU mode each activation vector is streamed once, kept in a small
// asynchronous-read buffer and replayed for the remaining NF-1 row groups.
//   ap_clk, ap_rst         : clock, synchronous active-high reset
//   s_axis_weights_*       : one [PE][SIMD] weight beat per compute beat
//   s_axis_input_*         : activations, only consumed in FILL
//   m_axis_output_*        : one [PE] result beat per row group, single-entry register
//
// state  | meaning
// FILL   | weights and activations consumed together; MVU stores activations
// REPLAY | weights only; activations come from the buffer (MVU with NF>1)
module mvu_replay_axi
  import mvu_replay_pkg::*;
#(
  parameter int IS_MVU             = 1,
  parameter int MW                 = 120,
  parameter int MH                 = 40,
  parameter int PE                 = 10,
  parameter int SIMD               = 20,
  parameter int ACTIVATION_WIDTH   = 4,
  parameter int WEIGHT_WIDTH       = 4,
  parameter int ACCU_WIDTH         = ACTIVATION_WIDTH + WEIGHT_WIDTH + $clog2(MW),
  parameter int SIGNED_ACTIVATIONS = 0
) (
  input  logic                                                          ap_clk,
  input  logic                                                          ap_rst,
  input  logic [ceil8(PE*SIMD*WEIGHT_WIDTH)-1:0]                        s_axis_weights_tdata,
  input  logic                                                          s_axis_weights_tvalid,
  output logic                                                          s_axis_weights_tready,
  input  logic [ceil8(((IS_MVU != 0) ? SIMD : PE*SIMD)*ACTIVATION_WIDTH)-1:0] s_axis_input_tdata,
  input  logic                                                          s_axis_input_tvalid,
  output logic                                                          s_axis_input_tready,
  output logic [ceil8(PE*ACCU_WIDTH)-1:0]                               m_axis_output_tdata,
  output logic                                                          m_axis_output_tvalid,
  input  logic                                                          m_axis_output_tready
);

  localparam int  SF         = MW / SIMD;
  localparam int  NF         = MH / PE;
  localparam int  AI         = (IS_MVU != 0) ? SIMD : PE*SIMD;
  localparam int  IW         = AI * ACTIVATION_WIDTH;
  localparam int  BW         = SIMD * ACTIVATION_WIDTH;
  localparam int  WW_ALL     = PE * SIMD * WEIGHT_WIDTH;
  localparam int  OW         = PE * ACCU_WIDTH;
  localparam int  OB         = ceil8(OW);
  localparam int  SFW        = cnt_w(SF);
  localparam int  NFW        = cnt_w(NF);
  localparam bit  HAS_REPLAY = (IS_MVU != 0) && (NF > 1);

  if (MW % SIMD != 0) begin : g_bad_mw
    $error("mvu_replay_axi: MW must be a multiple of SIMD");
  end
  if (MH % PE != 0) begin : g_bad_mh
    $error("mvu_replay_axi: MH must be a multiple of PE");
  end

  state_e           state_q;
  logic [SFW-1:0]   sf_q;
  logic [NFW-1:0]   nf_q;
  logic             out_vld_q;
  logic [OW-1:0]    out_data_q;
  logic [IW-1:0]    act_op;
  logic [OW-1:0]    acc_sum;
  logic             last_sf, last_nf, can_step, in_replay, fire;
  logic             unused_pad;

  assign last_sf   = (sf_q == SFW'(SF - 1));
  assign last_nf   = (nf_q == NFW'(NF - 1));
  // only the row-completing beat needs a free output register
  assign can_step  = !(last_sf && out_vld_q && !m_axis_output_tready);
  assign in_replay = (state_q == REPLAY);

  assign s_axis_weights_tready = !ap_rst && can_step && (in_replay || s_axis_input_tvalid);
  assign s_axis_input_tready   = !ap_rst && can_step && !in_replay && s_axis_weights_tvalid;
  assign fire                  = s_axis_weights_tvalid && s_axis_weights_tready;

  // tdata pad bits carry nothing
  assign unused_pad = ^{s_axis_weights_tdata, s_axis_input_tdata};

  if (IS_MVU != 0) begin : g_buf
    logic [BW-1:0] act_buf_q [SF];
    always_ff @(posedge ap_clk) begin
      if (fire && !in_replay) act_buf_q[sf_q] <= s_axis_input_tdata[BW-1:0];
    end
    assign act_op = in_replay ? act_buf_q[sf_q] : s_axis_input_tdata[IW-1:0];
  end else begin : g_nobuf
    assign act_op = s_axis_input_tdata[IW-1:0];
  end

  mvu_replay_dotp #(
    .IS_MVU             (IS_MVU),
    .PE                 (PE),
    .SIMD               (SIMD),
    .AI                 (AI),
    .ACTIVATION_WIDTH   (ACTIVATION_WIDTH),
    .WEIGHT_WIDTH       (WEIGHT_WIDTH),
    .ACCU_WIDTH         (ACCU_WIDTH),
    .SIGNED_ACTIVATIONS (SIGNED_ACTIVATIONS)
  ) u_dotp (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .en      (fire),
    .clr     (sf_q == '0),
    .act     (act_op),
    .wgt     (s_axis_weights_tdata[WW_ALL-1:0]),
    .acc_sum (acc_sum)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= FILL;
      sf_q       <= '0;
      nf_q       <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      if (out_vld_q && m_axis_output_tready) out_vld_q <= 1'b0;
      if (fire) begin
        if (last_sf) begin
          // a reload overrides the drain above, so rows run back to back
          out_vld_q  <= 1'b1;
          out_data_q <= acc_sum;
          sf_q       <= '0;
          if (last_nf) begin
            nf_q    <= '0;
            state_q <= FILL;
          end else begin
            nf_q    <= nf_q + 1'b1;
            state_q <= HAS_REPLAY ? REPLAY : FILL;
          end
        end else begin
          sf_q <= sf_q + 1'b1;
        end
      end
    end
  end

  assign m_axis_output_tvalid = out_vld_q;
  assign m_axis_output_tdata  = OB'(out_data_q);

endmodule

// File: tb/tb_mvu_replay_axi.sv
// Directed bench: a small MVU instance (MW=4, MH=4, PE=2, SIMD=2, unsigned
// activations) and a small VVU instance (MW=4, MH=2, PE=2, SIMD=2, signed).
module tb_mvu_replay_axi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ap_rst;

  logic [15:0] wd;  logic wv, w_rdy;
  logic [7:0]  id;  logic iv, i_rdy;
  logic [23:0] od;  logic ov, o_rdy;

  logic [15:0] vwd; logic vwv, vw_rdy;
  logic [15:0] vid; logic viv, vi_rdy;
  logic [23:0] vod; logic vov, vo_rdy;

  int checks = 0;
  int errors = 0;

  logic [23:0] outq[$];
  logic [23:0] voutq[$];

  mvu_replay_axi #(
    .IS_MVU(1), .MW(4), .MH(4), .PE(2), .SIMD(2),
    .ACTIVATION_WIDTH(4), .WEIGHT_WIDTH(4), .SIGNED_ACTIVATIONS(0)
  ) u_mvu (
    .ap_clk(clk), .ap_rst(ap_rst),
    .s_axis_weights_tdata(wd), .s_axis_weights_tvalid(wv), .s_axis_weights_tready(w_rdy),
    .s_axis_input_tdata(id), .s_axis_input_tvalid(iv), .s_axis_input_tready(i_rdy),
    .m_axis_output_tdata(od), .m_axis_output_tvalid(ov), .m_axis_output_tready(o_rdy)
  );

  mvu_replay_axi #(
    .IS_MVU(0), .MW(4), .MH(2), .PE(2), .SIMD(2),
    .ACTIVATION_WIDTH(4), .WEIGHT_WIDTH(4), .SIGNED_ACTIVATIONS(1)
  ) u_vvu (
    .ap_clk(clk), .ap_rst(ap_rst),
    .s_axis_weights_tdata(vwd), .s_axis_weights_tvalid(vwv), .s_axis_weights_tready(vw_rdy),
    .s_axis_input_tdata(vid), .s_axis_input_tvalid(viv), .s_axis_input_tready(vi_rdy),
    .m_axis_output_tdata(vod), .m_axis_output_tvalid(vov), .m_axis_output_tready(vo_rdy)
  );

  always @(negedge clk) begin
    if (!ap_rst && ov && o_rdy)   outq.push_back(od);
    if (!ap_rst && vov && vo_rdy) voutq.push_back(vod);
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [23:0] pk(input int c0, input int c1);
    logic [9:0] a, b;
    a = 10'(c0);
    b = 10'(c1);
    return {4'h0, b, a};
  endfunction

  function automatic logic [15:0] pw(input int e0, input int e1, input int e2, input int e3);
    return {4'(e3), 4'(e2), 4'(e1), 4'(e0)};
  endfunction

  function automatic logic [7:0] pa(input int a0, input int a1);
    return {4'(a1), 4'(a0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // present one weight beat (plus activation beat if with_in), wait for the handshake
  task automatic beat(input string tag, input logic [15:0] w, input logic [7:0] a,
                      input bit with_in, input bit exp_in);
    int  n;
    bit  got_in;
    wd = w; wv = 1'b1; id = a; iv = with_in; got_in = 1'b0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (w_rdy) begin
        got_in = i_rdy;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    wv = 1'b0; iv = 1'b0;
    chk({tag, "_lat"}, n, 0);
    chk({tag, "_in"}, got_in, exp_in);
  endtask

  task automatic vbeat(input string tag, input logic [15:0] w, input logic [15:0] a);
    int n;
    bit got_in;
    vwd = w; vwv = 1'b1; vid = a; viv = 1'b1; got_in = 1'b0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (vw_rdy) begin
        got_in = vi_rdy;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    vwv = 1'b0; viv = 1'b0;
    chk({tag, "_lat"}, n, 0);
    chk({tag, "_in"}, got_in, 1);
  endtask

  logic [23:0] exp_out [9];
  logic [23:0] got;

  initial begin
    ap_rst = 1'b1;
    wd = '0; wv = 1'b1; id = '0; iv = 1'b1; o_rdy = 1'b1;
    vwd = '0; vwv = 1'b0; vid = '0; viv = 1'b0; vo_rdy = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_wrdy", w_rdy, 0);
    chk("rst_irdy", i_rdy, 0);
    chk("rst_vld", ov, 0);
    chk("rst_dat", od, 0);
    chk("rst_vvld", vov, 0);
    chk("rst_vdat", vod, 0);
    wv = 1'b0; iv = 1'b0; ap_rst = 1'b0;

    // vector 1: a=[15,15,15,15], rows all -8 / all 7 / [1,2,3,4] / [-1,0,0,0]
    beat("v1n0s0", pw(-8, -8, 7, 7), pa(15, 15), 1, 1);
    beat("v1n0s1", pw(-8, -8, 7, 7), pa(15, 15), 1, 1);
    chk("v1_vld_rise", ov, 1);
    chk("v1_dat_rise", od, pk(-480, 420));
    beat("v1n1s0", pw(1, 2, -1, 0), 8'hAA, 1, 0);
    beat("v1n1s1", pw(3, 4, 0, 0), 8'hAA, 1, 0);
    // vector 2 back to back: a=[1,2,3,4]
    beat("v2n0s0", pw(1, 1, 2, -1), pa(1, 2), 1, 1);
    beat("v2n0s1", pw(1, 1, 0, 1), pa(3, 4), 1, 1);
    beat("v2n1s0", pw(0, 0, 7, 7), 8'h55, 1, 0);
    beat("v2n1s1", pw(0, -8, 7, 7), 8'h55, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("qlen_a", outq.size(), 4);

    // vector 3 with the output stalled: a=[3,0,0,5]
    o_rdy = 1'b0;
    beat("v3n0s0", pw(1, 0, 0, 0), pa(3, 0), 1, 1);
    beat("v3n0s1", pw(0, 1, 0, -1), pa(0, 5), 1, 1);
    beat("v3n1s0", pw(-8, 0, 2, 0), 8'hAA, 1, 0);
    wd = pw(0, -8, 0, 2); wv = 1'b1; id = 8'hAA; iv = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_wrdy", w_rdy, 0);
      chk("bp_irdy", i_rdy, 0);
      chk("bp_vld", ov, 1);
      chk("bp_dat", od, pk(8, -5));
      @(posedge clk); #1;
    end
    o_rdy = 1'b1;
    beat("v3n1s1", pw(0, -8, 0, 2), 8'hAA, 1, 0);

    // vector 4 interrupted by reset inside REPLAY, then fresh vector 5
    beat("v4n0s0", pw(1, 1, -1, -1), pa(1, 1), 1, 1);
    beat("v4n0s1", pw(1, 1, -1, -1), pa(1, 1), 1, 1);
    beat("v4n1s0", pw(5, 5, 5, 5), 8'hAA, 1, 0);
    ap_rst = 1'b1; wv = 1'b1; iv = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst2_vld", ov, 0);
    chk("rst2_wrdy", w_rdy, 0);
    chk("rst2_irdy", i_rdy, 0);
    wv = 1'b0; iv = 1'b0; ap_rst = 1'b0;
    beat("v5n0s0", pw(3, 0, -2, 0), pa(2, 0), 1, 1);
    beat("v5n0s1", pw(7, 7, 7, 7), pa(0, 0), 1, 1);
    beat("v5n1s0", pw(1, 0, -8, 0), 8'hAA, 1, 0);
    beat("v5n1s1", pw(0, 0, 0, 0), 8'hAA, 1, 0);
    repeat (3) @(posedge clk);
    #1;

    exp_out[0] = pk(-480, 420);
    exp_out[1] = pk(150, -15);
    exp_out[2] = pk(10, 4);
    exp_out[3] = pk(-32, 70);
    exp_out[4] = pk(8, -5);
    exp_out[5] = pk(-64, 16);
    exp_out[6] = pk(4, -4);
    exp_out[7] = pk(6, -4);
    exp_out[8] = pk(2, -16);
    chk("qlen_mvu", outq.size(), 9);
    for (int i = 0; i < 9; i++) begin
      got = (i < outq.size()) ? outq[i] : 24'hFFFFFF;
      chk($sformatf("mvu_out%0d", i), got, exp_out[i]);
    end

    // VVU: per-channel signed activations
    viv = 1'b1; vwv = 1'b0;
    #1;
    chk("vvu_in_nowgt", vi_rdy, 0);
    viv = 1'b0;
    @(posedge clk); #1;
    vbeat("w1s0", pw(-8, -8, 7, 7), pw(-8, -8, 1, -2));
    vbeat("w1s1", pw(-8, -8, -1, 2), pw(-8, -8, 3, 7));
    chk("vvu_vld_rise", vov, 1);
    chk("vvu_dat_rise", vod, pk(256, 4));
    vbeat("w2s0", pw(-8, -8, 1, 1), pw(7, 7, -1, -1));
    vbeat("w2s1", pw(-8, -8, 1, 1), pw(7, 7, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    chk("qlen_vvu", voutq.size(), 2);
    got = (voutq.size() > 0) ? voutq[0] : 24'hFFFFFF;
    chk("vvu_out0", got, pk(256, 4));
    got = (voutq.size() > 1) ? voutq[1] : 24'hFFFFFF;
    chk("vvu_out1", got, pk(-224, -2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
